uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
Frame-level controller behind the UART byte receiver in the lcd8 path. Detects completed bytes from the receiver's rx_int/rx_data pair and parses the frame AA | addr | len | payload[len] | csum. Buffers the payload, verifies the checksum, then replays the payload into LCD character memory through a ready/valid write port. Bad, short or stalled frames are discarded and flagged.

Parameters:
HDR, 8'hAA, frame header byte
ADDR_W, 5, LCD character memory address width (32 cells)
MAX_LEN, 16, maximum payload length; payload buffer depth
TIMEOUT_CYC, 500000, idle cycles between bytes before abort (10 ms at 50 MHz)

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
rx_int  in  1  receiver busy flag; high while a byte is in flight
rx_data  in  8  last received byte; stable when rx_int falls
wr_en  out  1  LCD memory write valid
wr_ready  in  1  LCD memory accepts write when high with wr_en
wr_addr  out  ADDR_W  LCD cell address
wr_data  out  8  character code
frame_ok  out  1  one-cycle pulse: frame committed completely
frame_err  out  1  one-cycle pulse: frame discarded
err_code  out  2  cause, held until next frame_err: 0 csum, 1 len, 2 timeout, 3 overrun
busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: single clock domain. Asynchronous active-low reset. Reset values: state IDLE, all outputs 0, err_code 0, counters 0. Reset mid-frame or mid-commit drops everything; no partial write completes after release.
- Byte strobe: register rx_int_q. byte_stb = rx_int_q & ~rx_int. Sample rx_data in the same cycle as byte_stb.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, COMMIT.
  - IDLE: byte_stb with rx_data==HDR goes to ADDR. Any other byte is ignored silently.
  - ADDR: latch base = rx_data[ADDR_W-1:0]. csum = rx_data. Go to LEN.
  - LEN: if rx_data==0 or rx_data>MAX_LEN, pulse frame_err with code 1 and return to IDLE. Otherwise latch len, csum ^= rx_data, idx = 0, go to DATA.
  - DATA: buf[idx] = rx_data, csum ^= rx_data, idx++. When idx reaches len, go to CSUM.
  - CSUM: if rx_data==csum, go to COMMIT with idx = 0. Otherwise pulse frame_err with code 0 and return to IDLE.
  - COMMIT: wr_en=1, wr_addr=(base+idx) mod 2^ADDR_W, wr_data=buf[idx]. idx advances only on the wr_en&wr_ready cycle. After the last accepted write: wr_en=0, frame_ok pulses the next cycle, return to IDLE.
- Write port: wr_addr and wr_data stay stable while wr_en=1 and wr_ready=0.
- Timeout: a cycle counter clears on every byte_stb and in IDLE/COMMIT. In ADDR/LEN/DATA/CSUM, when the counter reaches TIMEOUT_CYC-1, pulse frame_err with code 2 and go to IDLE.
- Overrun: byte_stb during COMMIT discards the byte, pulses frame_err with code 3, and the commit continues. frame_ok is still issued at the end of that commit.
- Simultaneous events: byte_stb and timeout in the same cycle means byte_stb wins and the counter clears.
- Latency: frame_ok = len + (wr_ready stall cycles) + 1 cycles after the checksum byte_stb. The first wr_en is asserted the cycle after the CSUM byte_stb.
- Widths: the checksum is an 8-bit XOR. The address add wraps silently with no error.

Decomposition:
- Package uart_frame_pkg holds:
  - state encoding localparams
  - ERR_CSUM=0, ERR_LEN=1, ERR_TMO=2, ERR_OVR=3
  - default HDR
- Sub-module frame_buf: MAX_LEN x 8 register file with a single write port (DATA) and a single async read port (COMMIT), indexed by $clog2(MAX_LEN).
- The FSM, counters and checksum stay in the top level.

Test Plan:
- Good frame: AA 03 02 41 42 csum=03^02^41^42=02, wr_ready=1 -> writes (3,'A'),(4,'B') on consecutive cycles; frame_ok pulses once; frame_err stays 0.
- Address wrap: AA 1F 02 31 32 csum=1E, wr_ready toggling 1/0 -> writes (1F,'1') then (00,'2'); data held during stalls; frame_ok pulses after the second accepted write.
- Bad checksum: AA 00 01 58 with csum FF -> no wr_en; frame_err pulses with err_code=0; a following valid frame commits normally.
- Bad length: AA 00 11 -> frame_err with code 1 at the len byte; the next bytes 41 42 are ignored in IDLE.
- Timeout: AA 05, then no byte for TIMEOUT_CYC cycles -> frame_err with code 2 exactly TIMEOUT_CYC cycles after the last byte_stb; busy drops the same cycle.
- Overrun and reset: with wr_ready held low in COMMIT, inject byte_stb -> frame_err with code 3 and commit resumes. Assert rst_n low mid-COMMIT -> wr_en=0 immediately; after release state is IDLE and no frame_ok is issued.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame controller: FSM state codes, error cause codes, default header.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_frame_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_LEN    = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CSUM   = 3'd4;
  localparam logic [2:0] ST_COMMIT = 3'd5;

  // frame_err cause codes reported on err_code
  localparam logic [1:0] ERR_CSUM = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

  localparam logic [7:0] HDR_DEFAULT = 8'hAA;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller owns sequencing of writes and reads.
// Ports: clk, rst_n | we_i, waddr_i, wdata_i (write) | raddr_i -> rdata_o (read).
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses AA|addr|len|payload|csum frames from the UART byte receiver and replays verified payloads to LCD memory.
// Latency: first wr_en the cycle after the checksum byte; frame_ok len + stall cycles + 1 after that byte.
// Backpressure: wr_en/wr_ready handshake; address and data hold while stalled. Receiver cannot be stalled (overrun flagged).
// Ports: clk, rst_n | rx_int, rx_data (receiver) | wr_en, wr_ready, wr_addr, wr_data (LCD write)
//        | frame_ok, frame_err, err_code, busy (status).
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR         = HDR_DEFAULT,
  parameter int         ADDR_W      = 5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_int,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic              rx_int_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              byte_stb;
  logic              wait_st;
  logic              tmo_hit;
  logic              buf_we;
  logic [LEN_W-1:0]  idx_inc;

  // A byte is complete on the falling edge of the receiver busy flag.
  assign byte_stb = rx_int_q & ~rx_int;
  assign idx_inc  = idx_q + LEN_W'(1);
  assign wait_st  = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);

  // Abort on the edge where the idle counter would reach TIMEOUT_CYC-1, so the
  // error pulse and the drop of busy land TIMEOUT_CYC cycles after the last strobe.
  // A strobe in the same cycle wins.
  assign tmo_hit = wait_st && !byte_stb && (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

  assign cnt_d = (byte_stb || !wait_st) ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (byte_stb && rx_data == HDR) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (byte_stb) begin
          base_d  = rx_data[ADDR_W-1:0];
          csum_d  = rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_stb) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d   = rx_data[LEN_W-1:0];
            csum_d  = csum_q ^ rx_data;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_stb) begin
          buf_we = 1'b1;
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_inc;
          if (idx_inc == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (byte_stb) begin
          if (rx_data == csum_q) begin
            idx_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_COMMIT: begin
        // A byte arriving now cannot be buffered; flag it but keep committing.
        if (byte_stb) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_OVR;
        end
        if (wr_ready) begin
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_q    <= 1'b0;
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      cnt_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_CSUM;
    end else begin
      rx_int_q    <= rx_int;
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (buf_we),
    .waddr_i (idx_q[IDX_W-1:0]),
    .wdata_i (rx_data),
    .raddr_i (idx_q[IDX_W-1:0]),
    .rdata_o (wr_data)
  );

  // Write port is decoded straight from registered state so reset kills it at once.
  assign wr_en     = (state_q == ST_COMMIT);
  assign wr_addr   = base_q + ADDR_W'(idx_q);
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: frame-level model plus directed literal expectations.
// Latency: n/a.
// Backpressure: wr_ready driven high, low or toggling per test.
module tb_uart_frame_ctrl;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_int = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_ready = 1'b1;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .HDR(8'hAA), .ADDR_W(5), .MAX_LEN(16), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_int(rx_int), .rx_data(rx_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stb = 0;
  int rdy_mode = 0;  // 0: ready high, 1: ready low, 2: toggle

  typedef struct { logic [4:0] a; logic [7:0] d; bit last; } wexp_t;
  typedef struct { int c; logic [4:0] a; logic [7:0] d; } wlog_t;
  typedef struct { int c; logic [1:0] code; logic bsy; } elog_t;

  wexp_t      wq[$];
  logic [1:0] eq[$];
  wlog_t      wlog[$];
  elog_t      elog[$];
  int         ok_log[$];
  logic [7:0] frm[$];
  bit         m_commit = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = 1'b0;
      default: wr_ready = ~wr_ready;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: collects bytes of a frame, decides the outcome when it is complete.
  task automatic model_byte(input logic [7:0] b);
    int len;
    logic [7:0] x;
    if (m_commit) begin
      eq.push_back(2'd3);
      return;
    end
    if (frm.size() == 0) begin
      if (b == 8'hAA) frm.push_back(b);
      return;
    end
    frm.push_back(b);
    if (frm.size() < 3) return;
    len = frm[2];
    if (frm.size() == 3 && (len == 0 || len > 16)) begin
      eq.push_back(2'd1);
      frm.delete();
      return;
    end
    if (frm.size() == 4 + len) begin
      x = 8'h00;
      for (int i = 1; i < frm.size() - 1; i++) x = x ^ frm[i];
      if (x == frm[frm.size() - 1]) begin
        for (int i = 0; i < len; i++) begin
          wexp_t w;
          w.a = 5'((int'(frm[1]) + i) % 32);
          w.d = frm[3 + i];
          w.last = (i == len - 1);
          wq.push_back(w);
        end
        m_commit = 1'b1;
      end else begin
        eq.push_back(2'd0);
      end
      frm.delete();
    end
  endtask

  task automatic model_timeout();
    if (frm.size() != 0) begin
      eq.push_back(2'd2);
      frm.delete();
    end
  endtask

  task automatic model_reset();
    wq.delete();
    eq.delete();
    frm.delete();
    m_commit = 1'b0;
  endtask

  // Compare process: checks every cycle outside reset.
  bit         ok_due = 1'b0;
  bit         prev_stall = 1'b0;
  logic [4:0] prev_a;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      ok_due = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_ok_timing", frame_ok, ok_due);
      if (frame_ok) begin
        ok_log.push_back(cyc);
        m_commit = 1'b0;
      end
      ok_due = 1'b0;
      if (prev_stall) begin
        chk("hold_wr_en", wr_en, 1'b1);
        chk("hold_wr_addr", wr_addr, prev_a);
        chk("hold_wr_data", wr_data, prev_d);
      end
      if (wr_en && wq.size() == 0) chk("unexpected_wr_en", wr_en, 1'b0);
      if (wr_en && wr_ready && wq.size() != 0) begin
        wexp_t e;
        wlog_t l;
        e = wq.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
        if (e.last) ok_due = 1'b1;
        l.c = cyc; l.a = wr_addr; l.d = wr_data;
        wlog.push_back(l);
      end
      prev_stall = wr_en & ~wr_ready;
      prev_a = wr_addr;
      prev_d = wr_data;
      if (frame_err) begin
        elog_t l;
        l.c = cyc; l.code = err_code; l.bsy = busy;
        elog.push_back(l);
        if (eq.size() == 0) chk("unexpected_frame_err", frame_err, 1'b0);
        else chk("err_code", err_code, eq.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_int = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_int = 1'b0;
    last_stb = cyc;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((wq.size() != 0 || m_commit) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: commit not drained within %0d cycles, %0d writes left", name, budget, wq.size());
    end
    idle(3);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: run did not end within 20000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, n0, e0, o0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_frame_ok", frame_ok, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_err_code", err_code, 2'd0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(3);

    // Good frame: AA 03 02 41 42 02
    n0 = wlog.size();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h02);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h02);
    c = last_stb;
    chk("model_q_len", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("model_w0_addr", wq[0].a, 5'h03);
      chk("model_w0_data", wq[0].d, 8'h41);
      chk("model_w1_addr", wq[1].a, 5'h04);
      chk("model_w1_data", wq[1].d, 8'h42);
    end
    drain("good", 50);
    chk("good_nwr", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
      chk("good_w0_cyc", wlog[n0].c, c + 1);
      chk("good_w0_addr", wlog[n0].a, 5'h03);
      chk("good_w0_data", wlog[n0].d, 8'h41);
      chk("good_w1_cyc", wlog[n0+1].c, c + 2);
      chk("good_w1_addr", wlog[n0+1].a, 5'h04);
    end
    chk("good_ok_cyc", (ok_log.size() > 0) ? ok_log[ok_log.size()-1] : -1, c + 3);

    // Address wrap with toggling ready: AA 1F 02 31 32 1E
    rdy_mode = 2;
    n0 = wlog.size();
    send_byte(8'hAA); send_byte(8'h1F); send_byte(8'h02);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h1E);
    drain("wrap", 50);
    rdy_mode = 0;
    chk("wrap_nwr", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) begin
      chk("wrap_w0_addr", wlog[n0].a, 5'h1F);
      chk("wrap_w0_data", wlog[n0].d, 8'h31);
      chk("wrap_w1_addr", wlog[n0+1].a, 5'h00);
      chk("wrap_w1_data", wlog[n0+1].d, 8'h32);
    end

    // Bad checksum, then a valid frame: AA 00 01 58 FF / AA 00 01 58 59
    e0 = elog.size();
    n0 = wlog.size();
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01); send_byte(8'h58); send_byte(8'hFF);
    idle(3);
    chk("csum_nerr", elog.size() - e0, 1);
    if (elog.size() > e0) chk("csum_code", elog[e0].code, 2'd0);
    chk("csum_nwr", wlog.size() - n0, 0);
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h01); send_byte(8'h58); send_byte(8'h59);
    drain("after_csum", 50);
    chk("after_csum_nwr", wlog.size() - n0, 1);
    if (wlog.size() > n0) chk("after_csum_data", wlog[n0].d, 8'h58);

    // Bad length: AA 00 11, then 41 42 ignored
    e0 = elog.size();
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h11);
    send_byte(8'h41); send_byte(8'h42);
    idle(3);
    chk("len_nerr", elog.size() - e0, 1);
    if (elog.size() > e0) chk("len_code", elog[e0].code, 2'd1);
    chk("len_busy", busy, 1'b0);

    // Timeout: AA 05 then silence
    send_byte(8'hAA); send_byte(8'h05);
    model_timeout();
    repeat (T) @(negedge clk);
    chk("tmo_early_err", frame_err, 1'b0);
    chk("tmo_early_busy", busy, 1'b1);
    @(negedge clk);
    chk("tmo_err", frame_err, 1'b1);
    chk("tmo_code", err_code, 2'd2);
    chk("tmo_busy", busy, 1'b0);
    idle(3);

    // Overrun: AA 08 02 61 62 09 with ready low, extra byte during commit
    rdy_mode = 1;
    e0 = elog.size();
    o0 = ok_log.size();
    n0 = wlog.size();
    send_byte(8'hAA); send_byte(8'h08); send_byte(8'h02);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h09);
    idle(3);
    chk("ovr_in_commit", wr_en, 1'b1);
    send_byte(8'h55);
    idle(3);
    chk("ovr_nerr", elog.size() - e0, 1);
    if (elog.size() > e0) chk("ovr_code", elog[e0].code, 2'd3);
    rdy_mode = 0;
    drain("overrun", 50);
    chk("ovr_nok", ok_log.size() - o0, 1);
    chk("ovr_nwr", wlog.size() - n0, 2);
    if (wlog.size() >= n0 + 2) chk("ovr_w1_addr", wlog[n0+1].a, 5'h09);

    // Reset mid-commit: AA 10 01 77 66 with ready low
    rdy_mode = 1;
    o0 = ok_log.size();
    n0 = wlog.size();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h01); send_byte(8'h77); send_byte(8'h66);
    idle(3);
    chk("rstc_in_commit", wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstc_wr_en", wr_en, 1'b0);
    chk("rstc_busy", busy, 1'b0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(12);
    chk("rstc_busy_after", busy, 1'b0);
    chk("rstc_nok", ok_log.size() - o0, 0);
    chk("rstc_nwr", wlog.size() - n0, 0);

    chk("end_writes_left", wq.size(), 0);
    chk("end_errs_left", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
